// File: rtl/cci_mpf_shim_tx_credit.sv
// Credit-gated Tx consumer stage.
// Pops the AFU-side request buffer heads for C0 (reads) and C1 (writes and
// interrupts) and forwards each popped request to the QLP through a single
// register stage. Pops are held off by QLP almost-full and by the outstanding
// read/write credit counters; Rx responses return credits.
module cci_mpf_shim_tx_credit #(
    parameter int CCI_DATA_WIDTH   = 512,
    parameter int CCI_TX_HDR_WIDTH = 61,
    parameter int MAX_RD_OUT       = 64,
    parameter int MAX_WR_OUT       = 64,
    localparam int RW = $clog2(MAX_RD_OUT + 1),
    localparam int WW = $clog2(MAX_WR_OUT + 1)
) (
    input  logic                        clk,
    input  logic                        resetb,

    input  logic                        buf_c0_valid,
    input  logic [CCI_TX_HDR_WIDTH-1:0] buf_c0_hdr,
    input  logic                        buf_c1_wr_valid,
    input  logic                        buf_c1_ir_valid,
    input  logic [CCI_TX_HDR_WIDTH-1:0] buf_c1_hdr,
    input  logic [CCI_DATA_WIDTH-1:0]   buf_c1_data,
    output logic                        deq_c0,
    output logic                        deq_c1,

    input  logic                        qlp_c0_alm_full,
    input  logic                        qlp_c1_alm_full,
    output logic                        qlp_c0_rd_valid,
    output logic [CCI_TX_HDR_WIDTH-1:0] qlp_c0_hdr,
    output logic                        qlp_c1_wr_valid,
    output logic                        qlp_c1_ir_valid,
    output logic [CCI_TX_HDR_WIDTH-1:0] qlp_c1_hdr,
    output logic [CCI_DATA_WIDTH-1:0]   qlp_c1_data,

    input  logic                        rx_c0_rd_valid,
    input  logic                        rx_c1_wr_valid,
    output logic [RW-1:0]               rd_out_cnt,
    output logic [WW-1:0]               wr_out_cnt,
    output logic                        credit_err
);

    localparam logic [RW-1:0] RD_MAX = RW'(MAX_RD_OUT);
    localparam logic [WW-1:0] WR_MAX = WW'(MAX_WR_OUT);

    // Credit counters and sticky underflow flag
    logic [RW-1:0] rd_cnt_q, rd_cnt_d;
    logic [WW-1:0] wr_cnt_q, wr_cnt_d;
    logic          err_q, err_d;
    logic          rd_underflow;
    logic          wr_underflow;

    // Register stage toward the QLP
    logic                        c0_vld_q;
    logic [CCI_TX_HDR_WIDTH-1:0] c0_hdr_q;
    logic                        c1_wr_q;
    logic                        c1_ir_q;
    logic [CCI_TX_HDR_WIDTH-1:0] c1_hdr_q;
    logic [CCI_DATA_WIDTH-1:0]   c1_data_q;

    // Pop qualifiers for the C1 head; a write takes priority if both flags are set
    logic c1_pop_wr;
    logic c1_pop_ir;

    // Pop decision: gated on the registered count, so a same-cycle credit
    // return cannot enable a pop while the counter sits at MAX.
    always_comb begin
        deq_c0 = resetb & buf_c0_valid & ~qlp_c0_alm_full & (rd_cnt_q < RD_MAX);
        deq_c1 = resetb & (buf_c1_wr_valid | buf_c1_ir_valid) & ~qlp_c1_alm_full &
                 (~buf_c1_wr_valid | (wr_cnt_q < WR_MAX));
        c1_pop_wr = deq_c1 & buf_c1_wr_valid;
        c1_pop_ir = deq_c1 & buf_c1_ir_valid & ~buf_c1_wr_valid;
    end

    // Read credit next-state: pop adds one, response returns one, floor at zero
    always_comb begin
        rd_cnt_d     = rd_cnt_q;
        rd_underflow = 1'b0;
        case ({deq_c0, rx_c0_rd_valid})
            2'b10:   rd_cnt_d = rd_cnt_q + 1'b1;
            2'b01: begin
                if (rd_cnt_q == '0) begin
                    rd_underflow = 1'b1;
                end else begin
                    rd_cnt_d = rd_cnt_q - 1'b1;
                end
            end
            default: rd_cnt_d = rd_cnt_q;
        endcase
    end

    // Write credit next-state: only writes consume credit, interrupts are free
    always_comb begin
        wr_cnt_d     = wr_cnt_q;
        wr_underflow = 1'b0;
        case ({c1_pop_wr, rx_c1_wr_valid})
            2'b10:   wr_cnt_d = wr_cnt_q + 1'b1;
            2'b01: begin
                if (wr_cnt_q == '0) begin
                    wr_underflow = 1'b1;
                end else begin
                    wr_cnt_d = wr_cnt_q - 1'b1;
                end
            end
            default: wr_cnt_d = wr_cnt_q;
        endcase
    end

    // Sticky error: any response that arrives with nothing outstanding
    always_comb begin
        err_d = err_q | rd_underflow | wr_underflow;
    end

    // Credit state registers
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            err_q    <= err_d;
        end
    end

    // C0 output stage: valid is re-armed only by a pop, header captured on pop
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            c0_vld_q <= 1'b0;
            c0_hdr_q <= '0;
        end else begin
            c0_vld_q <= deq_c0;
            if (deq_c0) begin
                c0_hdr_q <= buf_c0_hdr;
            end
        end
    end

    // C1 output stage: one beat per pop, header and data held between pops
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            c1_wr_q   <= 1'b0;
            c1_ir_q   <= 1'b0;
            c1_hdr_q  <= '0;
            c1_data_q <= '0;
        end else begin
            c1_wr_q <= c1_pop_wr;
            c1_ir_q <= c1_pop_ir;
            if (deq_c1) begin
                c1_hdr_q  <= buf_c1_hdr;
                c1_data_q <= buf_c1_data;
            end
        end
    end

    assign qlp_c0_rd_valid = c0_vld_q;
    assign qlp_c0_hdr      = c0_hdr_q;
    assign qlp_c1_wr_valid = c1_wr_q;
    assign qlp_c1_ir_valid = c1_ir_q;
    assign qlp_c1_hdr      = c1_hdr_q;
    assign qlp_c1_data     = c1_data_q;
    assign rd_out_cnt      = rd_cnt_q;
    assign wr_out_cnt      = wr_cnt_q;
    assign credit_err      = err_q;

endmodule
